mult_seq_ctrl: RTL and testbench

- FSM controller that sequences a shift-add multiplier datapath.
- The datapath is a partial-product register (en_PPReg, 2*DATA_WIDTH wide, with carry), a multiplier shift register and an adder.
- The controller accepts a start request, loads the operands, runs DATA_WIDTH add/shift iterations and pulses done.
- One instance sits beside each multiplier lane in the matrix-multiply processing element.

---
 rtl/mult_ctrl_pkg.sv | 9 +
 rtl/mult_seq_ctrl_iter_counter.sv | 18 +
 rtl/mult_seq_ctrl.sv | 55 +++++
 tb/tb_mult_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: state encoding shared by the shift-add multiplier controller
package mult_ctrl_pkg;
  localparam int STATE_W = 3;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/mult_seq_ctrl_iter_counter.sv
// iter_counter: iteration counter with clear, saturating increment and terminal-count flag
module iter_counter #(
  parameter int CNT_WIDTH = 3,
  parameter logic [CNT_WIDTH-1:0] LAST = '1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);
  assign tc = cnt == LAST;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: FSM sequencing a shift-add multiplier datapath (load, DATA_WIDTH add/shift pairs, done)
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 multiplier_lsb,
  output logic                 busy,
  output logic                 done,
  output logic                 ld_Mreg,
  output logic                 clr_PPReg,
  output logic                 en_PPReg,
  output logic                 add_sel,
  output logic                 shift_en,
  output logic [CNT_WIDTH-1:0] iter_cnt
);
  logic [STATE_W-1:0] state, nxt;
  logic live, tc;
  assign busy      = state != S_IDLE;
  assign live      = busy && !abort;
  assign ld_Mreg   = live && state == S_LOAD;
  assign clr_PPReg = ld_Mreg;
  assign en_PPReg  = live && state == S_ADD;
  assign shift_en  = live && state == S_SHIFT;
  assign done      = live && state == S_DONE;
  // the ternary keeps an undriven lsb from leaking out outside ADD
  assign add_sel   = en_PPReg ? multiplier_lsb : 1'b0;
  always_comb begin
    nxt = S_IDLE;
    if (state == S_IDLE) nxt = start ? S_LOAD : S_IDLE;
    else if (!abort)
      nxt = state == S_LOAD  ? S_ADD :
            state == S_ADD   ? S_SHIFT :
            state == S_SHIFT ? (tc ? S_DONE : S_ADD) : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= nxt;
  iter_counter #(
    .CNT_WIDTH(CNT_WIDTH),
    .LAST     (CNT_WIDTH'(DATA_WIDTH - 1))
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (busy && (abort || state == S_LOAD)),
    .inc    (shift_en),
    .cnt    (iter_cnt),
    .tc     (tc)
  );
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized self-checking bench against a phase-based reference model
module tb_mult_seq_ctrl;
  localparam int W = 8;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, lsb = 0;
  logic start4 = 0, abort4 = 0, lsb4 = 0;
  logic busy, done, ld_Mreg, clr_PPReg, en_PPReg, add_sel, shift_en;
  logic [2:0] iter_cnt;
  logic busy4, done4, ld4, clr4, en4, as4, sh4;
  logic [1:0] iter4;
  logic [9:0] obs, exp_v;
  logic [7:0] a5 = 8'hA5;
  int total = 0, bad = 0, cyc = 0;
  bit m_act = 0;
  int m_p = 0, m_iter = 0;

  always #5 clk = ~clk;
  assign obs = {busy, done, ld_Mreg, clr_PPReg, en_PPReg, add_sel, shift_en, iter_cnt};

  mult_seq_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .multiplier_lsb(lsb),
    .busy(busy), .done(done), .ld_Mreg(ld_Mreg), .clr_PPReg(clr_PPReg), .en_PPReg(en_PPReg),
    .add_sel(add_sel), .shift_en(shift_en), .iter_cnt(iter_cnt)
  );
  mult_seq_ctrl #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .abort(abort4), .multiplier_lsb(lsb4),
    .busy(busy4), .done(done4), .ld_Mreg(ld4), .clr_PPReg(clr4), .en_PPReg(en4),
    .add_sel(as4), .shift_en(sh4), .iter_cnt(iter4)
  );

  // model: phase 0 = load, odd phases add, even phases 2..2W shift, 2W+1 done
  function automatic bit in_add();
    return m_act && m_p % 2 == 1 && m_p <= 2*W-1;
  endfunction

  task automatic model_outputs();
    bit live = m_act && !abort;
    bit ld = live && m_p == 0;
    bit en = live && in_add();
    bit sh = live && m_p % 2 == 0 && m_p >= 2 && m_p <= 2*W;
    bit dn = live && m_p == 2*W+1;
    exp_v = {m_act, dn, ld, ld, en, en ? lsb : 1'b0, sh, 3'(m_iter)};
  endtask

  task automatic step_model();
    if (!m_act) begin
      if (start) begin m_act = 1; m_p = 0; end
    end else if (abort) begin
      m_act = 0; m_iter = 0;
    end else begin
      m_p++;
      if (m_p > 2*W+1) m_act = 0;
      else m_iter = (m_p-1)/2 < W-1 ? (m_p-1)/2 : W-1;
    end
  endtask

  task automatic drive(input logic st, input logic ab, input logic l);
    @(negedge clk);
    start = st; abort = ab; lsb = l;
    #1 model_outputs();
  endtask

  task automatic adv();
    @(posedge clk);
    step_model();
    cyc++;
  endtask

  task automatic test_reset();
    int n = 0;
    reset_n = 0; start = 1; lsb = 1'bx;
    repeat (2) @(negedge clk);
    #1 total++;
    if (obs !== 10'd0) begin bad++; $display("FAIL reset_state obs=%b exp=0", obs); end
    @(negedge clk);
    start = 0; reset_n = 1; m_act = 0; m_iter = 0;
    drive(1, 0, 1'bx);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_start obs=%b exp=%b", obs, exp_v); end
    adv();
    while (!(m_act && m_p == 8) && n < 40) begin
      drive(0, 0, in_add() ? 1'($urandom) : 1'bx);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_run cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      adv(); n++;
    end
    drive(0, 0, 1'bx);
    total++;
    if (obs !== exp_v || !shift_en || iter_cnt !== 3'd3) begin
      bad++; $display("FAIL reset_pre_shift obs=%b exp=%b", obs, exp_v);
    end
    #2 reset_n = 0;
    #1 total++;
    if (obs !== 10'd0) begin bad++; $display("FAIL reset_mid_shift obs=%b exp=0", obs); end
    @(posedge clk);
    m_act = 0; m_iter = 0;
    @(negedge clk) reset_n = 1;
    repeat (20) begin
      drive(0, 0, 1'bx);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_after cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      adv();
    end
  endtask

  task automatic test_a5();
    bit exp_as[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int k = 0, dones = 0, s, dcyc = -1, n = 0;
    drive(1, 0, 1'bx);
    adv();
    s = cyc;
    while (m_act && n < 40) begin
      drive(0, 0, in_add() ? a5[m_iter[2:0]] : 1'bx);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL a5_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL a5_busy cyc=%0d busy=%b exp=1", cyc, busy); end
      if (en_PPReg === 1'b1 && k < 8) begin
        total++;
        if (add_sel !== exp_as[k]) begin bad++; $display("FAIL a5_add_sel k=%0d got=%b exp=%b", k, add_sel, exp_as[k]); end
        k++;
      end
      if (done === 1'b1) begin dones++; dcyc = cyc; end
      adv(); n++;
    end
    total++;
    if (k != 8) begin bad++; $display("FAIL a5_adds got=%0d exp=8", k); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL a5_done_count got=%0d exp=1", dones); end
    total++;
    if (dcyc - s + 1 != 18) begin bad++; $display("FAIL a5_latency got=%0d exp=18", dcyc - s + 1); end
  endtask

  task automatic test_back_to_back();
    int dq[$], lq[$];
    int n = 0;
    repeat (45) begin
      drive(1, 0, in_add() ? 1'($urandom) : 1'bx);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL b2b_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (done === 1'b1) dq.push_back(cyc);
      if (ld_Mreg === 1'b1) lq.push_back(cyc);
      adv();
    end
    while (m_act && n < 40) begin drive(0, 0, 1'b0); adv(); n++; end
    total++;
    if (dq.size() < 2) begin bad++; $display("FAIL b2b_dones got=%0d exp=2", dq.size()); end
    else begin
      total++;
      if (dq[1] - dq[0] != 19) begin bad++; $display("FAIL b2b_spacing got=%0d exp=19", dq[1] - dq[0]); end
      total++;
      if (lq.size() < 2 || lq[1] != dq[0] + 2) begin bad++; $display("FAIL b2b_reload got=%0d exp=%0d", lq.size() > 1 ? lq[1] : -1, dq[0] + 2); end
    end
  endtask

  task automatic test_abort();
    int n = 0, s, dcyc = -1;
    drive(1, 0, 1'bx);
    adv();
    while (!(m_act && m_p == 11) && n < 40) begin
      drive(0, 0, in_add() ? 1'($urandom) : 1'bx);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL abort_run cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      adv(); n++;
    end
    drive(0, 1, 1'b1);
    total++;
    if (obs !== exp_v || en_PPReg !== 1'b0 || add_sel !== 1'b0 || iter_cnt !== 3'd5) begin
      bad++; $display("FAIL abort_cycle obs=%b exp=%b", obs, exp_v);
    end
    adv();
    drive(0, 0, 1'bx);
    total++;
    if (obs !== exp_v || busy !== 1'b0 || iter_cnt !== 3'd0) begin
      bad++; $display("FAIL abort_after obs=%b exp=%b", obs, exp_v);
    end
    adv();
    drive(1, 0, 1'bx);
    adv();
    s = cyc; n = 0;
    while (m_act && n < 40) begin
      drive(0, 0, in_add() ? 1'($urandom) : 1'bx);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL abort_rerun cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      if (done === 1'b1) dcyc = cyc;
      adv(); n++;
    end
    total++;
    if (dcyc - s + 1 != 18) begin bad++; $display("FAIL abort_rerun_latency got=%0d exp=18", dcyc - s + 1); end
  endtask

  task automatic test_random();
    logic prev_done = 0;
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, 1'($urandom));
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rand_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v); end
      total++;
      if (int'(ld_Mreg) + int'(en_PPReg) + int'(shift_en) > 1) begin
        bad++; $display("FAIL rand_overlap cyc=%0d ld=%b en=%b sh=%b exp=onehot0", cyc, ld_Mreg, en_PPReg, shift_en);
      end
      total++;
      if (iter_cnt > 3'd7 || $isunknown(iter_cnt)) begin bad++; $display("FAIL rand_iter cyc=%0d got=%0d exp<=7", cyc, iter_cnt); end
      total++;
      if (done && prev_done) begin bad++; $display("FAIL rand_done_pulse cyc=%0d got=11 exp=single", cyc); end
      prev_done = done;
      adv();
    end
    start = 0; abort = 1;
    adv();
    abort = 0;
  endtask

  task automatic test_width4();
    int q[$];
    int n = 1;
    @(negedge clk) start4 = 1;
    @(negedge clk) start4 = 0;
    #1;
    while (done4 !== 1'b1 && n < 30) begin
      if (sh4 === 1'b1) q.push_back(int'(iter4));
      lsb4 = 1'($urandom);
      @(negedge clk);
      #1 n++;
    end
    total++;
    if (n != 10) begin bad++; $display("FAIL w4_latency got=%0d exp=10", n); end
    total++;
    if (q.size() != 4 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3) begin
      bad++; $display("FAIL w4_iter_seq got=%p exp=0,1,2,3", q);
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_abort();
    test_random();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
